lane_distributor: RTL and testbench

Transmit-side lane distribution stage feeding the logical-layer encoder. It stripes 16-bit transport-layer words across lane 0 and lane 1 and frames the byte stream into 8-byte (Gen2) or 16-byte (Gen3) blocks. Within each block it inserts ordered sets on request and scrambles transport bytes per lane. Its outputs connect directly to the encoder's `lane_0_tx`, `lane_1_tx`, `d_sel`, `gen_speed` and `enable` inputs.

---
 rtl/usb4_lane_pkg.sv | 48 ++++
 rtl/lane_distributor_if.sv | 29 ++
 rtl/lane_scrambler.sv | 30 +++
 rtl/lane_distributor.sv | 130 +++++++++++++
 tb/tb_lane_distributor.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb4_lane_pkg.sv
// rtl/usb4_lane_pkg.sv - shared constants, state enum and LFSR helper for the lane distributor
package usb4_lane_pkg;

  localparam logic [3:0] D_SEL_TL   = 4'd8;
  localparam logic [3:0] D_SEL_IDLE = 4'd9;

  localparam logic [1:0] GEN4     = 2'd0;
  localparam logic [1:0] GEN3     = 2'd1;
  localparam logic [1:0] GEN2     = 2'd2;
  localparam logic [1:0] GEN_RSVD = 2'd3;

  localparam int BLK_LEN_GEN2 = 8;
  localparam int BLK_LEN_GEN3 = 16;
  localparam int OS_LEN_GEN4  = 8;

  localparam logic [22:0] SEED_LANE0 = 23'h1DBFBC;
  localparam logic [22:0] SEED_LANE1 = 23'h0607BB;
  // x^23 + x^21 + x^16 + x^8 + x^5 + x^2 + 1, Galois form with x^23 implied
  localparam logic [22:0] LFSR_TAPS  = 23'h210125;

  typedef enum logic [1:0] {ST_IDLE, ST_TL_BLK, ST_OS_BLK} lane_state_e;

  typedef struct packed {
    logic [22:0] state;
    logic [7:0]  key;
  } lfsr_step_t;

  function automatic logic [3:0] blk_last(input logic [1:0] spd, input logic is_os);
    case (spd)
      GEN3:    return 4'(BLK_LEN_GEN3 - 1);
      GEN2:    return 4'(BLK_LEN_GEN2 - 1);
      default: return is_os ? 4'(OS_LEN_GEN4 - 1) : 4'd0;
    endcase
  endfunction

  // Key bit i is the MSB before step i; eight steps per byte.
  function automatic lfsr_step_t lfsr_advance8(input logic [22:0] s);
    lfsr_step_t r;
    r.state = s;
    r.key   = '0;
    for (int i = 0; i < 8; i++) begin
      r.key[i] = r.state[22];
      r.state  = {r.state[21:0], 1'b0} ^ (r.state[22] ? LFSR_TAPS : 23'd0);
    end
    return r;
  endfunction

endpackage

// File: rtl/lane_distributor_if.sv
// rtl/lane_distributor_if.sv - transport, ordered-set and lane output bundle of the lane distributor
interface lane_distributor_if;
  logic        link_en;
  logic [1:0]  gen_speed_in;
  logic [15:0] tl_data;
  logic        tl_valid;
  logic        tl_ready;
  logic        os_req;
  logic [3:0]  os_sel;
  logic [63:0] os_payload;
  logic        os_ack;
  logic [7:0]  lane_0_tx;
  logic [7:0]  lane_1_tx;
  logic [3:0]  d_sel;
  logic [1:0]  gen_speed;
  logic        enable;
  logic        block_start;
  logic        tl_fill;

  modport master (
    output link_en, gen_speed_in, tl_data, tl_valid, os_req, os_sel, os_payload,
    input  tl_ready, os_ack, lane_0_tx, lane_1_tx, d_sel, gen_speed, enable, block_start, tl_fill
  );

  modport slave (
    input  link_en, gen_speed_in, tl_data, tl_valid, os_req, os_sel, os_payload,
    output tl_ready, os_ack, lane_0_tx, lane_1_tx, d_sel, gen_speed, enable, block_start, tl_fill
  );
endinterface

// File: rtl/lane_scrambler.sv
// rtl/lane_scrambler.sv - one 23-bit lane LFSR, byte-wide advance with reseed
module lane_scrambler
  import usb4_lane_pkg::*;
#(
  parameter logic [22:0] SEED = SEED_LANE0
) (
  input  logic       enc_clk,
  input  logic       rst,
  input  logic       reseed_i,
  input  logic       adv_i,
  output logic [7:0] key_o
);

  logic [22:0] lfsr_q, lfsr_d;
  lfsr_step_t  step;

  always_comb begin
    step   = lfsr_advance8(lfsr_q);
    key_o  = step.key;
    lfsr_d = lfsr_q;
    if (reseed_i)   lfsr_d = SEED;
    else if (adv_i) lfsr_d = step.state;
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED;
    else      lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/lane_distributor.sv
// rtl/lane_distributor.sv - stripes transport words over two lanes with Gen2/Gen3/Gen4 block framing
// Per-lane scrambling of transport bytes is present only when LANE_SCRAMBLER_EN is defined.
module lane_distributor
  import usb4_lane_pkg::*;
(
  input  logic              enc_clk,
  input  logic              rst,
  lane_distributor_if.slave lane_if
);

  lane_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pay_q, pay_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  lane0_q, lane0_d, lane1_q, lane1_d;
  logic [3:0]  d_sel_q, d_sel_d;
  logic [1:0]  gen_speed_q, gen_speed_d;
  logic        enable_q, enable_d;
  logic        block_start_q, block_start_d;
  logic        tl_fill_q, tl_fill_d;

  logic        active, boundary, os_go, is_tl;
  lane_state_e blk;
  logic [1:0]  spd;
  logic [63:0] pay_cur;
  logic [3:0]  sel_cur;
  logic [7:0]  os_byte, key0, key1;

  // cnt_q == 0 is the boundary: the byte issued now opens a new block.
  assign active   = lane_if.link_en && (lane_if.gen_speed_in != GEN_RSVD);
  assign boundary = (cnt_q == 4'd0);
  assign os_go    = lane_if.os_req && !lane_if.os_sel[3];
  assign blk      = boundary ? (os_go ? ST_OS_BLK : ST_TL_BLK) : state_q;
  assign spd      = boundary ? lane_if.gen_speed_in : gen_speed_q;
  assign pay_cur  = boundary ? lane_if.os_payload : pay_q;
  assign sel_cur  = boundary ? lane_if.os_sel : sel_q;
  assign os_byte  = pay_cur[{cnt_q[2:0], 3'b000} +: 8];
  assign is_tl    = active && (blk == ST_TL_BLK);

`ifdef LANE_SCRAMBLER_EN
  logic scr_reseed, scr_adv;
  assign scr_reseed = !active;
  assign scr_adv    = is_tl;

  lane_scrambler #(.SEED(SEED_LANE0)) u_scr_lane0 (
    .enc_clk(enc_clk), .rst(rst), .reseed_i(scr_reseed), .adv_i(scr_adv), .key_o(key0)
  );
  lane_scrambler #(.SEED(SEED_LANE1)) u_scr_lane1 (
    .enc_clk(enc_clk), .rst(rst), .reseed_i(scr_reseed), .adv_i(scr_adv), .key_o(key1)
  );
`else
  assign key0 = 8'h00;
  assign key1 = 8'h00;
`endif

  always_comb begin
    state_d       = ST_IDLE;
    cnt_d         = 4'd0;
    pay_d         = pay_q;
    sel_d         = sel_q;
    lane0_d       = 8'h00;
    lane1_d       = 8'h00;
    d_sel_d       = D_SEL_IDLE;
    gen_speed_d   = GEN4;
    enable_d      = 1'b0;
    block_start_d = 1'b0;
    tl_fill_d     = 1'b0;
    if (active) begin
      state_d       = blk;
      cnt_d         = (cnt_q == blk_last(spd, blk == ST_OS_BLK)) ? 4'd0 : cnt_q + 4'd1;
      gen_speed_d   = spd;
      enable_d      = 1'b1;
      block_start_d = boundary;
      if (boundary && os_go) begin
        pay_d = lane_if.os_payload;
        sel_d = lane_if.os_sel;
      end
      if (blk == ST_OS_BLK) begin
        lane0_d = os_byte;
        lane1_d = os_byte;
        d_sel_d = sel_cur;
      end else begin
        lane0_d   = (lane_if.tl_valid ? lane_if.tl_data[7:0]  : 8'h00) ^ key0;
        lane1_d   = (lane_if.tl_valid ? lane_if.tl_data[15:8] : 8'h00) ^ key1;
        d_sel_d   = D_SEL_TL;
        tl_fill_d = !lane_if.tl_valid;
      end
    end
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      pay_q         <= '0;
      sel_q         <= 4'd0;
      lane0_q       <= 8'h00;
      lane1_q       <= 8'h00;
      d_sel_q       <= D_SEL_IDLE;
      gen_speed_q   <= GEN4;
      enable_q      <= 1'b0;
      block_start_q <= 1'b0;
      tl_fill_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pay_q         <= pay_d;
      sel_q         <= sel_d;
      lane0_q       <= lane0_d;
      lane1_q       <= lane1_d;
      d_sel_q       <= d_sel_d;
      gen_speed_q   <= gen_speed_d;
      enable_q      <= enable_d;
      block_start_q <= block_start_d;
      tl_fill_q     <= tl_fill_d;
    end
  end

  // Handshakes are combinational so ack/ready land in the sampling cycle; held low in reset.
  assign lane_if.tl_ready    = rst && is_tl;
  assign lane_if.os_ack      = rst && active && boundary && os_go;
  assign lane_if.lane_0_tx   = lane0_q;
  assign lane_if.lane_1_tx   = lane1_q;
  assign lane_if.d_sel       = d_sel_q;
  assign lane_if.gen_speed   = gen_speed_q;
  assign lane_if.enable      = enable_q;
  assign lane_if.block_start = block_start_q;
  assign lane_if.tl_fill     = tl_fill_q;

endmodule

// File: tb/tb_lane_distributor.sv
// tb/tb_lane_distributor.sv - vector table, directed corner sequences and random traffic against a block-level model
module tb_lane_distributor;

  logic enc_clk;
  logic rst;
  lane_distributor_if lif();

  lane_distributor u_dut (.enc_clk(enc_clk), .rst(rst), .lane_if(lif));

  initial enc_clk = 1'b0;
  always #5 enc_clk = ~enc_clk;

`ifdef LANE_SCRAMBLER_EN
  localparam bit SCR_ON = 1'b1;
`else
  localparam bit SCR_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: bytes remaining in the current block, position, block kind, LFSR words.
  int          m_rem, m_pos;
  logic        m_os;
  logic [1:0]  m_spd;
  logic [63:0] m_pay;
  logic [3:0]  m_sel;
  int          m_s0, m_s1;
  logic [7:0]  m_ku0, m_ku1;
  logic [7:0]  e_l0, e_l1;
  logic [3:0]  e_dsel;
  logic [1:0]  e_spd;
  logic        e_en, e_bs, e_fill, e_rdy, e_ack;
  logic        act_rdy, act_ack;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic scr_key(inout int s, output logic [7:0] key);
    int b;
    key = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b      = (s >> 22) & 1;
      key[i] = b[0];
      s      = ((s << 1) & 32'h7FFFFF) ^ ((b != 0) ? 32'h210125 : 32'h0);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_pos = 0; m_os = 1'b0; m_spd = 2'd0;
    m_s0 = 32'h1DBFBC; m_s1 = 32'h0607BB;
    m_ku0 = 8'h00; m_ku1 = 8'h00;
    e_l0 = 8'h00; e_l1 = 8'h00; e_dsel = 4'd9; e_spd = 2'd0;
    e_en = 1'b0; e_bs = 1'b0; e_fill = 1'b0; e_rdy = 1'b0; e_ack = 1'b0;
  endtask

  task automatic model_cycle();
    int         len;
    logic [7:0] k0, k1, d0, d1;
    if (!lif.link_en || lif.gen_speed_in == 2'd3) begin
      model_reset();
      return;
    end
    e_ack = 1'b0;
    e_bs  = 1'b0;
    if (m_rem == 0) begin
      m_spd = lif.gen_speed_in;
      m_os  = lif.os_req && (lif.os_sel <= 4'd7);
      if (m_os) begin
        m_pay = lif.os_payload;
        m_sel = lif.os_sel;
      end
      case (m_spd)
        2'd1:    len = 16;
        2'd2:    len = 8;
        default: len = m_os ? 8 : 1;
      endcase
      m_rem = len; m_pos = 0;
      e_ack = m_os; e_bs = 1'b1;
    end
    e_rdy = !m_os; e_en = 1'b1; e_spd = m_spd; e_fill = 1'b0;
    if (m_os) begin
      e_l0 = m_pay[8*(m_pos%8) +: 8];
      e_l1 = e_l0;
      e_dsel = m_sel;
      m_ku0 = 8'h00; m_ku1 = 8'h00;
    end else begin
      d0 = lif.tl_valid ? lif.tl_data[7:0]  : 8'h00;
      d1 = lif.tl_valid ? lif.tl_data[15:8] : 8'h00;
      scr_key(m_s0, k0);
      scr_key(m_s1, k1);
      m_ku0 = SCR_ON ? k0 : 8'h00;
      m_ku1 = SCR_ON ? k1 : 8'h00;
      e_l0 = d0 ^ m_ku0; e_l1 = d1 ^ m_ku1;
      e_dsel = 4'd8; e_fill = !lif.tl_valid;
    end
    m_pos++;
    m_rem--;
  endtask

  task automatic run_cycle(input logic link, input logic [1:0] spd, input logic [15:0] data,
                           input logic valid, input logic req, input logic [3:0] sel,
                           input logic [63:0] pay);
    lif.link_en = link; lif.gen_speed_in = spd; lif.tl_data = data; lif.tl_valid = valid;
    lif.os_req = req; lif.os_sel = sel; lif.os_payload = pay;
    #1;
    model_cycle();
    act_rdy = lif.tl_ready;
    act_ack = lif.os_ack;
    check("handshake", 64'({act_rdy, act_ack}), 64'({e_rdy, e_ack}));
    @(posedge enc_clk); #1;
    check("lanes", 64'({lif.lane_0_tx, lif.lane_1_tx}), 64'({e_l0, e_l1}));
    check("ctrl", 64'({lif.d_sel, lif.gen_speed, lif.enable, lif.block_start, lif.tl_fill}),
          64'({e_dsel, e_spd, e_en, e_bs, e_fill}));
  endtask

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        req;
    logic [3:0]  sel;
    logic [7:0]  l0;
    logic [7:0]  l1;
    logic        bs;
    logic        fill;
    logic        ack;
  } vec_t;

  vec_t        tbl [17];
  logic [7:0]  kseq [9];
  int          ks;
  logic [1:0]  r_spd;
  logic        r_req;
  logic [3:0]  r_sel;
  localparam logic [63:0] PAY = 64'h0706050403020100;

  initial begin
    // Gen2: one continuous block, then a block opened under an illegal OS select with a 2-slot underrun.
    tbl[0]  = '{1'b1, 16'h0100, 1'b0, 4'd0, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0201, 1'b0, 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0302, 1'b0, 4'd0, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0403, 1'b0, 4'd0, 8'h03, 8'h04, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 16'h0504, 1'b0, 4'd0, 8'h04, 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 16'h0605, 1'b0, 4'd0, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 16'h0706, 1'b0, 4'd0, 8'h06, 8'h07, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 16'h0807, 1'b0, 4'd0, 8'h07, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 16'h1110, 1'b1, 4'd9, 8'h10, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 16'h1312, 1'b0, 4'd0, 8'h12, 8'h13, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h1514, 1'b0, 4'd0, 8'h14, 8'h15, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'hDEAD, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 16'hBEEF, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 16'h1716, 1'b0, 4'd0, 8'h16, 8'h17, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 16'h1918, 1'b0, 4'd0, 8'h18, 8'h19, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 16'h1B1A, 1'b0, 4'd0, 8'h1A, 8'h1B, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 16'h1D1C, 1'b0, 4'd0, 8'h1C, 8'h1D, 1'b1, 1'b0, 1'b0};

    ks = 32'h1DBFBC;
    for (int i = 0; i < 9; i++) scr_key(ks, kseq[i]);

    // Power-on reset with requests present: handshakes must stay low.
    rst = 1'b0;
    lif.link_en = 1'b1; lif.gen_speed_in = 2'd2; lif.tl_data = 16'h0; lif.tl_valid = 1'b1;
    lif.os_req = 1'b1; lif.os_sel = 4'd2; lif.os_payload = PAY;
    model_reset();
    repeat (2) @(posedge enc_clk);
    #1;
    check("reset_hs", 64'({lif.tl_ready, lif.os_ack}), 64'd0);
    check("reset_out", 64'({lif.lane_0_tx, lif.lane_1_tx, lif.d_sel, lif.gen_speed, lif.enable,
                            lif.block_start, lif.tl_fill}), 64'({16'h0, 4'd9, 2'd0, 3'b000}));
    lif.link_en = 1'b0;
    rst = 1'b1;

    run_cycle(1'b0, 2'd2, 16'h0, 1'b0, 1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 17; i++) begin
      run_cycle(1'b1, 2'd2, tbl[i].d, tbl[i].v, tbl[i].req, tbl[i].sel, PAY);
      check("tbl_lanes", 64'({lif.lane_0_tx, lif.lane_1_tx}),
            64'({tbl[i].l0 ^ m_ku0, tbl[i].l1 ^ m_ku1}));
      check("tbl_ctrl", 64'({lif.d_sel, lif.block_start, lif.tl_fill, act_rdy, act_ack}),
            64'({4'd8, tbl[i].bs, tbl[i].fill, 1'b1, tbl[i].ack}));
    end

    // Gen3 ordered set: ack at the boundary, 16 bytes repeating payload, no transport accepted.
    run_cycle(1'b0, 2'd1, 16'h0, 1'b0, 1'b0, 4'd0, 64'd0);
    run_cycle(1'b1, 2'd1, 16'hAAAA, 1'b1, 1'b1, 4'd3, PAY);
    check("os_ack_pulse", 64'({act_ack, act_rdy}), 64'({1'b1, 1'b0}));
    for (int i = 0; i < 16; i++) begin
      check("os_byte", 64'({lif.lane_0_tx, lif.lane_1_tx, lif.d_sel, lif.gen_speed}),
            64'({8'(i % 8), 8'(i % 8), 4'd3, 2'd1}));
      run_cycle(1'b1, 2'd1, 16'h5A5A, 1'b1, 1'b0, 4'd0, 64'd0);
      if (i < 15) check("os_no_ready", 64'({act_rdy, act_ack}), 64'd0);
    end
    check("os_then_tl", 64'({lif.block_start, lif.d_sel}), 64'({1'b1, 4'd8}));

    // Scrambler keys from the seed, and no LFSR advance across an ordered-set block.
    run_cycle(1'b0, 2'd2, 16'h0, 1'b0, 1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 8; i++) begin
      run_cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 4'd0, 64'd0);
      if (i == 0) check("scr_first", 64'(lif.lane_0_tx), 64'(SCR_ON ? kseq[0] : 8'h00));
    end
    run_cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b1, 4'd5, 64'h1122334455667788);
    for (int i = 0; i < 7; i++) run_cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 4'd0, 64'd0);
    run_cycle(1'b1, 2'd2, 16'h0000, 1'b1, 1'b0, 4'd0, 64'd0);
    check("scr_after_os", 64'(lif.lane_0_tx), 64'(SCR_ON ? kseq[8] : 8'h00));

    // Link drop at Gen3 byte 5, then restart from cnt 0.
    run_cycle(1'b0, 2'd1, 16'h0, 1'b0, 1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 5; i++) run_cycle(1'b1, 2'd1, 16'h3344 + 16'(i), 1'b1, 1'b0, 4'd0, 64'd0);
    run_cycle(1'b0, 2'd1, 16'h7777, 1'b1, 1'b0, 4'd0, 64'd0);
    check("drop_idle", 64'({lif.d_sel, lif.enable, lif.lane_0_tx}), 64'({4'd9, 1'b0, 8'h00}));
    run_cycle(1'b1, 2'd1, 16'h0000, 1'b1, 1'b0, 4'd0, 64'd0);
    check("drop_restart", 64'({lif.block_start, lif.enable, lif.lane_0_tx}),
          64'({1'b1, 1'b1, SCR_ON ? kseq[0] : 8'h00}));

    // Random traffic over all speeds, link toggles, illegal selects and Gen4 ordered sets.
    r_spd = 2'd2; r_req = 1'b0; r_sel = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) r_spd = 2'($urandom_range(0, 3));
      if (r_req && act_ack) r_req = 1'b0;
      else if (!r_req && $urandom_range(0, 9) == 0) begin
        r_req = 1'b1;
        r_sel = 4'($urandom_range(0, 9));
      end else if (r_req && r_sel > 4'd7 && $urandom_range(0, 3) == 0) r_sel = 4'($urandom_range(0, 9));
      run_cycle($urandom_range(0, 59) != 0, r_spd, 16'($urandom), $urandom_range(0, 3) != 0,
                r_req, r_sel, {$urandom, $urandom});
    end

    // Asynchronous reset in the middle of a Gen2 block.
    run_cycle(1'b0, 2'd2, 16'h0, 1'b0, 1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'd2, 16'hA5C3, 1'b1, 1'b0, 4'd0, 64'd0);
    rst = 1'b0;
    #1;
    check("midrst_hs", 64'({lif.tl_ready, lif.os_ack}), 64'd0);
    @(posedge enc_clk); #1;
    check("midrst_out", 64'({lif.lane_0_tx, lif.lane_1_tx, lif.d_sel, lif.gen_speed, lif.enable,
                             lif.block_start, lif.tl_fill}), 64'({16'h0, 4'd9, 2'd0, 3'b000}));
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'd2, 16'h1234, 1'b1, 1'b0, 4'd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
